// File: rtl/xeng_vacc_if.sv
// Signal bundle for xeng_vacc: x-engine word stream in, integrated dump stream out.
// The master drives the input stream and observes the dump; the accumulator is the slave.
interface xeng_vacc_if #(
    parameter int ACC_WIDTH  = 38,
    parameter int OUT_HALF   = 23,
    parameter int ADDR_W     = 6,
    parameter int MCNT_WIDTH = 48
);
    logic                  sync_in;
    logic [ACC_WIDTH-1:0]  din;
    logic                  vld_in;
    logic [MCNT_WIDTH-1:0] mcnt_in;
    logic [2*OUT_HALF-1:0] dout;
    logic                  dout_vld;
    logic [ADDR_W-1:0]     dout_addr;
    logic                  dout_first;
    logic [MCNT_WIDTH-1:0] dout_mcnt;
    logic [31:0]           int_cnt;

    modport master (
        output sync_in, din, vld_in, mcnt_in,
        input  dout, dout_vld, dout_addr, dout_first, dout_mcnt, int_cnt
    );

    modport slave (
        input  sync_in, din, vld_in, mcnt_in,
        output dout, dout_vld, dout_addr, dout_first, dout_mcnt, int_cnt
    );
endinterface

// File: rtl/xeng_vacc.sv
// Long-term vector accumulator: integrates 2^ACC_LEN_BITS x-engine windows word by word
// in a BRAM and streams out the integrated vector during the last window.
module xeng_vacc #(
    parameter int N_ANTS       = 10,
    parameter int ACC_WIDTH    = 38,
    parameter int ACC_LEN_BITS = 4,
    parameter int MCNT_WIDTH   = 48
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ce,
    xeng_vacc_if.slave bus
);
    localparam int N_WORDS  = N_ANTS * (N_ANTS / 2 + 1);
    localparam int IN_HALF  = ACC_WIDTH / 2;
    localparam int OUT_HALF = IN_HALF + ACC_LEN_BITS;
    localparam int ADDR_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int WIN_W    = (ACC_LEN_BITS > 0) ? ACC_LEN_BITS : 1;

    localparam logic [ADDR_W-1:0]     ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]     ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]     LAST_WORD = ADDR_W'(N_WORDS - 1);
    localparam logic [WIN_W-1:0]      ZERO_WIN  = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]      ONE_WIN   = WIN_W'(1);
    localparam logic [WIN_W-1:0]      LAST_WIN  = WIN_W'((1 << ACC_LEN_BITS) - 1);
    localparam logic [OUT_HALF-1:0]   ZERO_HALF = {OUT_HALF{1'b0}};
    localparam logic [MCNT_WIDTH-1:0] ZERO_MCNT = {MCNT_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [OUT_HALF-1:0] sext_half(input logic [IN_HALF-1:0] x);
        return OUT_HALF'($signed(x));
    endfunction

    state_t                r_state;
    logic [ADDR_W-1:0]     r_word_ctr;
    logic [WIN_W-1:0]      r_win_ctr;
    logic [MCNT_WIDTH-1:0] r_mcnt_cap;

    logic                  r_s1_vld;
    logic [ADDR_W-1:0]     r_s1_addr;
    logic [ACC_WIDTH-1:0]  r_s1_din;
    logic                  r_s1_first_win;
    logic                  r_s1_dump_win;
    logic [MCNT_WIDTH-1:0] r_s1_mcnt;

    logic [2*OUT_HALF-1:0] r_mem [N_WORDS];
    logic [2*OUT_HALF-1:0] r_rd_data;

    logic [2*OUT_HALF-1:0] r_dout;
    logic                  r_dout_vld;
    logic [ADDR_W-1:0]     r_dout_addr;
    logic                  r_dout_first;
    logic [MCNT_WIDTH-1:0] r_dout_mcnt;
    logic [31:0]           r_int_cnt;

    logic                  w_accept;
    logic [ADDR_W-1:0]     w_word;
    logic [WIN_W-1:0]      w_win;
    logic                  w_first_win;
    logic                  w_dump_win;
    logic                  w_int_start;
    logic [ADDR_W-1:0]     w_word_nxt;
    logic [WIN_W-1:0]      w_win_nxt;
    logic [OUT_HALF-1:0]   w_base_re;
    logic [OUT_HALF-1:0]   w_base_im;
    logic [OUT_HALF-1:0]   w_sum_re;
    logic [OUT_HALF-1:0]   w_sum_im;

    // ce exists only for Simulink compatibility and has no effect.
    logic w_unused_ce;
    assign w_unused_ce = ce;

    // Acceptance and counter advance; a sync makes the current sample word 0 of window 0.
    always_comb begin
        w_accept = bus.vld_in & (bus.sync_in | (r_state == ST_RUN));
        if (bus.sync_in) begin
            w_word = ZERO_ADDR;
            w_win  = ZERO_WIN;
        end else begin
            w_word = r_word_ctr;
            w_win  = r_win_ctr;
        end
        w_first_win = (w_win == ZERO_WIN);
        w_dump_win  = (w_win == LAST_WIN);
        w_int_start = (w_word == ZERO_ADDR) & w_first_win;
        w_word_nxt  = w_word;
        w_win_nxt   = w_win;
        if (w_accept) begin
            if (w_word == LAST_WORD) begin
                w_word_nxt = ZERO_ADDR;
                if (w_win == LAST_WIN) begin
                    w_win_nxt = ZERO_WIN;
                end else begin
                    w_win_nxt = w_win + ONE_WIN;
                end
            end else begin
                w_word_nxt = w_word + ONE_ADDR;
                w_win_nxt  = w_win;
            end
        end else begin
            w_word_nxt = w_word;
            w_win_nxt  = w_win;
        end
    end

    // Control state, counters, timestamp capture and the stage-1 pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_word_ctr     <= ZERO_ADDR;
            r_win_ctr      <= ZERO_WIN;
            r_mcnt_cap     <= ZERO_MCNT;
            r_s1_vld       <= 1'b0;
            r_s1_addr      <= ZERO_ADDR;
            r_s1_din       <= {ACC_WIDTH{1'b0}};
            r_s1_first_win <= 1'b0;
            r_s1_dump_win  <= 1'b0;
            r_s1_mcnt      <= ZERO_MCNT;
        end else begin
            if (bus.sync_in) begin
                r_state <= ST_RUN;
            end
            r_word_ctr <= w_word_nxt;
            r_win_ctr  <= w_win_nxt;
            if (w_accept && w_int_start) begin
                r_mcnt_cap <= bus.mcnt_in;
            end
            r_s1_vld       <= w_accept;
            r_s1_addr      <= w_word;
            r_s1_din       <= bus.din;
            r_s1_first_win <= w_first_win;
            r_s1_dump_win  <= w_dump_win;
            // Each word carries its own integration's timestamp so in-flight dump words
            // survive a restart that recaptures the timestamp.
            r_s1_mcnt      <= w_int_start ? bus.mcnt_in : r_mcnt_cap;
        end
    end

    // Window 0 ignores the stored value, which also clears the previous integration.
    always_comb begin
        if (r_s1_first_win) begin
            w_base_re = ZERO_HALF;
            w_base_im = ZERO_HALF;
        end else begin
            w_base_re = r_rd_data[2*OUT_HALF-1:OUT_HALF];
            w_base_im = r_rd_data[OUT_HALF-1:0];
        end
        w_sum_re = w_base_re + sext_half(r_s1_din[ACC_WIDTH-1:IN_HALF]);
        w_sum_im = w_base_im + sext_half(r_s1_din[IN_HALF-1:0]);
    end

    // Accumulator RAM: registered read at acceptance, write-back one cycle later.
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[w_word];
        if (r_s1_vld) begin
            r_mem[r_s1_addr] <= {w_sum_re, w_sum_im};
        end
    end

    // Dump output registers; everything except dout_vld holds between dumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= {(2 * OUT_HALF){1'b0}};
            r_dout_vld   <= 1'b0;
            r_dout_addr  <= ZERO_ADDR;
            r_dout_first <= 1'b0;
            r_dout_mcnt  <= ZERO_MCNT;
            r_int_cnt    <= 32'd0;
        end else begin
            r_dout_vld <= r_s1_vld & r_s1_dump_win;
            if (r_s1_vld && r_s1_dump_win) begin
                r_dout       <= {w_sum_re, w_sum_im};
                r_dout_addr  <= r_s1_addr;
                r_dout_first <= (r_s1_addr == ZERO_ADDR);
                r_dout_mcnt  <= r_s1_mcnt;
                if (r_s1_addr == LAST_WORD) begin
                    r_int_cnt <= r_int_cnt + 32'd1;
                end
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_vld   = r_dout_vld;
    assign bus.dout_addr  = r_dout_addr;
    assign bus.dout_first = r_dout_first;
    assign bus.dout_mcnt  = r_dout_mcnt;
    assign bus.int_cnt    = r_int_cnt;
endmodule

// File: tb/tb_xeng_vacc.sv
// Scoreboard bench for xeng_vacc: one instance integrating 4 windows, one pass-through,
// both fed the same random-ish stream and checked against a window-sum reference model.
module tb_xeng_vacc;
    localparam int N_WORDS = 12;
    localparam int OH_A    = 12;
    localparam int OH_B    = 10;

    typedef struct {
        int          re;
        int          im;
        int          addr;
        bit          first;
        logic [47:0] mcnt;
        int          icnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_s = 1'b0;
    logic        vld_s = 1'b0;
    logic [19:0] din_s = 20'd0;
    logic [47:0] mcnt_s = 48'd0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    bit          run_m[2];
    int          word_m[2];
    int          win_m[2];
    int          dumps_m[2];
    logic [47:0] cap_m[2];
    int          sum_re[2][N_WORDS];
    int          sum_im[2][N_WORDS];

    always #5 clk = ~clk;

    xeng_vacc_if #(.ACC_WIDTH(20), .OUT_HALF(OH_A), .ADDR_W(4), .MCNT_WIDTH(48)) bus_a ();
    xeng_vacc_if #(.ACC_WIDTH(20), .OUT_HALF(OH_B), .ADDR_W(4), .MCNT_WIDTH(48)) bus_b ();

    assign bus_a.sync_in = sync_s;
    assign bus_a.vld_in  = vld_s;
    assign bus_a.din     = din_s;
    assign bus_a.mcnt_in = mcnt_s;
    assign bus_b.sync_in = sync_s;
    assign bus_b.vld_in  = vld_s;
    assign bus_b.din     = din_s;
    assign bus_b.mcnt_in = mcnt_s;

    xeng_vacc #(.N_ANTS(4), .ACC_WIDTH(20), .ACC_LEN_BITS(2), .MCNT_WIDTH(48)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(1'b1), .bus(bus_a)
    );
    xeng_vacc #(.N_ANTS(4), .ACC_WIDTH(20), .ACC_LEN_BITS(0), .MCNT_WIDTH(48)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(1'b1), .bus(bus_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integration = sum of window values per word; dump during the last window.
    task automatic model_sample(input int id, input int t);
        int   re;
        int   im;
        int   nw;
        bit   acc;
        exp_t e;
        nw  = (id == 0) ? 4 : 1;
        re  = int'($signed(din_s[19:10]));
        im  = int'($signed(din_s[9:0]));
        acc = vld_s && (sync_s || run_m[id]);
        if (sync_s) begin
            run_m[id]  = 1'b1;
            word_m[id] = 0;
            win_m[id]  = 0;
        end
        if (acc) begin
            if (word_m[id] == 0 && win_m[id] == 0) cap_m[id] = mcnt_s;
            if (win_m[id] == 0) begin
                sum_re[id][word_m[id]] = re;
                sum_im[id][word_m[id]] = im;
            end else begin
                sum_re[id][word_m[id]] += re;
                sum_im[id][word_m[id]] += im;
            end
            if (win_m[id] == nw - 1) begin
                if (word_m[id] == N_WORDS - 1) dumps_m[id]++;
                e.re    = sum_re[id][word_m[id]];
                e.im    = sum_im[id][word_m[id]];
                e.addr  = word_m[id];
                e.first = (word_m[id] == 0);
                e.mcnt  = cap_m[id];
                e.icnt  = dumps_m[id];
                e.cyc   = t + 2;
                if (id == 0) q_a.push_back(e);
                else         q_b.push_back(e);
            end
            word_m[id]++;
            if (word_m[id] == N_WORDS) begin
                word_m[id] = 0;
                win_m[id]  = (win_m[id] + 1) % nw;
            end
        end
    endtask

    // The model consumes the sample presented during the cycle that this edge closes.
    always @(posedge clk) begin
        if (rst_n) begin
            model_sample(0, cyc);
            model_sample(1, cyc);
        end
        cyc = cyc + 1;
    end

    task automatic check_out(input int id, input int re, input int im, input int addr,
                             input bit first, input logic [47:0] mcnt, input int icnt);
        exp_t  e;
        string tag;
        tag = (id == 0) ? "A" : "B";
        if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_spurious: dout_vld at cycle %0d addr %0d with nothing expected",
                     tag, cyc, addr);
        end else begin
            if (id == 0) e = q_a.pop_front();
            else         e = q_b.pop_front();
            chk({tag, "_re"},    longint'(re),    longint'(e.re));
            chk({tag, "_im"},    longint'(im),    longint'(e.im));
            chk({tag, "_addr"},  longint'(addr),  longint'(e.addr));
            chk({tag, "_first"}, longint'(first), longint'(e.first));
            chk({tag, "_mcnt"},  longint'(mcnt),  longint'(e.mcnt));
            chk({tag, "_icnt"},  longint'(icnt),  longint'(e.icnt));
            chk({tag, "_lat"},   longint'(cyc),   longint'(e.cyc));
        end
    endtask

    // Monitor: compare every presented dump word against the head of its queue.
    always @(negedge clk) begin
        if (bus_a.dout_vld)
            check_out(0, int'($signed(bus_a.dout[23:12])), int'($signed(bus_a.dout[11:0])),
                      int'(bus_a.dout_addr), bus_a.dout_first, bus_a.dout_mcnt, int'(bus_a.int_cnt));
        if (bus_b.dout_vld)
            check_out(1, int'($signed(bus_b.dout[19:10])), int'($signed(bus_b.dout[9:0])),
                      int'(bus_b.dout_addr), bus_b.dout_first, bus_b.dout_mcnt, int'(bus_b.int_cnt));
    end

    task automatic drive(input bit s, input bit v, input int re, input int im);
        @(posedge clk);
        #1;
        sync_s = s;
        vld_s  = v;
        din_s  = {re[9:0], im[9:0]};
        mcnt_s = {16'($urandom), $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_dout"},  longint'(bus_a.dout),       0);
        chk({tag, "_a_vld"},   longint'(bus_a.dout_vld),   0);
        chk({tag, "_a_addr"},  longint'(bus_a.dout_addr),  0);
        chk({tag, "_a_first"}, longint'(bus_a.dout_first), 0);
        chk({tag, "_a_mcnt"},  longint'(bus_a.dout_mcnt),  0);
        chk({tag, "_a_icnt"},  longint'(bus_a.int_cnt),    0);
        chk({tag, "_b_dout"},  longint'(bus_b.dout),       0);
        chk({tag, "_b_vld"},   longint'(bus_b.dout_vld),   0);
        chk({tag, "_b_addr"},  longint'(bus_b.dout_addr),  0);
        chk({tag, "_b_first"}, longint'(bus_b.dout_first), 0);
        chk({tag, "_b_mcnt"},  longint'(bus_b.dout_mcnt),  0);
        chk({tag, "_b_icnt"},  longint'(bus_b.int_cnt),    0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sync_s = 1'b0;
        vld_s  = 1'b0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < 2; i++) begin
            run_m[i]   = 1'b0;
            word_m[i]  = 0;
            win_m[i]   = 0;
            dumps_m[i] = 0;
            cap_m[i]   = 48'd0;
        end
    endtask

    function automatic int rnd_half();
        return int'($urandom_range(1023, 0)) - 512;
    endfunction

    initial begin
        int n;
        bit v;
        apply_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant 3/-2 over two full integrations.
        drive(1'b1, 1'b1, 3, -2);
        for (int i = 1; i < 96; i++) drive(1'b0, 1'b1, 3, -2);
        idle(4);

        // real = window index, imag = word index across two integrations.
        for (int i = 0; i < 96; i++) drive(i == 0, 1'b1, (i / 12) % 4, i % 12);
        idle(4);

        // Random gaps in vld with random data.
        drive(1'b1, 1'b1, rnd_half(), rnd_half());
        n = 1;
        while (n < 96) begin
            v = 1'($urandom_range(1, 0));
            drive(1'b0, v, rnd_half(), rnd_half());
            if (v) n++;
        end
        idle(4);

        // Restart at sample 30, then a full fresh integration.
        drive(1'b1, 1'b1, rnd_half(), rnd_half());
        for (int i = 1; i < 30; i++) drive(1'b0, 1'b1, rnd_half(), rnd_half());
        drive(1'b1, 1'b1, rnd_half(), rnd_half());
        for (int i = 1; i < 48; i++) drive(1'b0, 1'b1, rnd_half(), rnd_half());
        idle(4);
        chk("abort_icnt_a", longint'(bus_a.int_cnt), longint'(dumps_m[0]));

        // -5/+7 stream: pass-through instance echoes it.
        drive(1'b1, 1'b1, -5, 7);
        for (int i = 1; i < 24; i++) drive(1'b0, 1'b1, -5, 7);
        idle(4);
        chk("pass_icnt_b", longint'(bus_b.int_cnt), longint'(dumps_m[1]));

        // Reset while the accumulating instance is mid-dump.
        drive(1'b1, 1'b1, rnd_half(), rnd_half());
        for (int i = 1; i < 42; i++) drive(1'b0, 1'b1, rnd_half(), rnd_half());
        @(posedge clk);
        #3;
        apply_reset();
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, rnd_half(), rnd_half());
        idle(3);
        chk("nosync_a_vld", longint'(bus_a.int_cnt), 0);
        drive(1'b1, 1'b1, rnd_half(), rnd_half());
        for (int i = 1; i < 48; i++) drive(1'b0, 1'b1, rnd_half(), rnd_half());
        idle(6);

        chk("drain_a", longint'(q_a.size()), 0);
        chk("drain_b", longint'(q_b.size()), 0);
        chk("final_icnt_a", longint'(bus_a.int_cnt), longint'(dumps_m[0]));
        chk("final_icnt_b", longint'(bus_b.int_cnt), longint'(dumps_m[1]));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
